// File: rtl/decode_queue.sv
// Buffered MIPS decode stage: decodes each fetched instruction as it is
// enqueued and presents the decoded entries in order over valid/ready.
// Unknown is not stored; it is implied by a stored instruction number of 0.
module decode_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32,
   parameter int IRN_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_ir,
   input  logic [PC_W-1:0]          in_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_ir,
   output logic [PC_W-1:0]          out_pc,
   output logic [IRN_W-1:0]         out_irn,
   output logic [3:0]               out_irtype,
   output logic                     out_unknown,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]     mem_ir   [DEPTH];
   logic [PC_W-1:0] mem_pc   [DEPTH];
   logic [5:0]      mem_irn  [DEPTH];
   logic [3:0]      mem_type [DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic            push, pop;
   logic [5:0]      opcode, funct;
   logic [4:0]      rt;
   logic [5:0]      dec_num;
   logic [3:0]      dec_type;

   assign opcode    = in_ir[31:26];
   assign rt        = in_ir[20:16];
   assign funct     = in_ir[5:0];
   assign in_ready  = (count < CW'(DEPTH)) & ~reset;
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Instruction number from opcode/funct/rt; 0 means unsupported.
   always_comb begin
      dec_num = '0;
      case (opcode)
         6'h00: begin
            case (funct)
               6'h20: dec_num = 6'd1;   6'h21: dec_num = 6'd2;
               6'h22: dec_num = 6'd3;   6'h23: dec_num = 6'd4;
               6'h00: dec_num = 6'd5;   6'h02: dec_num = 6'd6;
               6'h03: dec_num = 6'd7;   6'h04: dec_num = 6'd8;
               6'h06: dec_num = 6'd9;   6'h07: dec_num = 6'd10;
               6'h24: dec_num = 6'd11;  6'h25: dec_num = 6'd12;
               6'h26: dec_num = 6'd13;  6'h27: dec_num = 6'd14;
               6'h2a: dec_num = 6'd15;  6'h2b: dec_num = 6'd16;
               6'h18: dec_num = 6'd17;  6'h19: dec_num = 6'd18;
               6'h1a: dec_num = 6'd19;  6'h1b: dec_num = 6'd20;
               6'h11: dec_num = 6'd21;  6'h13: dec_num = 6'd22;
               6'h10: dec_num = 6'd23;  6'h12: dec_num = 6'd24;
               6'h08: dec_num = 6'd49;  6'h09: dec_num = 6'd50;
               default: dec_num = '0;
            endcase
         end
         6'h01: begin
            case (rt)
               5'h00:   dec_num = 6'd45;
               5'h01:   dec_num = 6'd46;
               default: dec_num = '0;
            endcase
         end
         6'h02: dec_num = 6'd47;  6'h03: dec_num = 6'd48;
         6'h04: dec_num = 6'd41;  6'h05: dec_num = 6'd42;
         6'h06: dec_num = 6'd43;  6'h07: dec_num = 6'd44;
         6'h08: dec_num = 6'd25;  6'h09: dec_num = 6'd26;
         6'h0a: dec_num = 6'd31;  6'h0b: dec_num = 6'd32;
         6'h0c: dec_num = 6'd27;  6'h0d: dec_num = 6'd28;
         6'h0e: dec_num = 6'd29;  6'h0f: dec_num = 6'd30;
         6'h20: dec_num = 6'd34;  6'h21: dec_num = 6'd36;
         6'h23: dec_num = 6'd33;  6'h24: dec_num = 6'd35;
         6'h25: dec_num = 6'd37;  6'h28: dec_num = 6'd40;
         6'h29: dec_num = 6'd39;  6'h2b: dec_num = 6'd38;
         default: dec_num = '0;
      endcase
   end

   // Instruction class follows from the instruction-number ranges.
   always_comb begin
      dec_type = 4'd0;
      case (dec_num) inside
         [6'd5:6'd7]:   dec_type = 4'd1;
         [6'd8:6'd10]:  dec_type = 4'd2;
         [6'd17:6'd20]: dec_type = 4'd3;
         [6'd21:6'd22]: dec_type = 4'd4;
         [6'd23:6'd24]: dec_type = 4'd5;
         [6'd25:6'd29]: dec_type = 4'd6;
         6'd30:         dec_type = 4'd7;
         [6'd31:6'd32]: dec_type = 4'd6;
         [6'd33:6'd37]: dec_type = 4'd8;
         [6'd38:6'd40]: dec_type = 4'd9;
         [6'd41:6'd42]: dec_type = 4'd10;
         [6'd43:6'd46]: dec_type = 4'd11;
         6'd47:         dec_type = 4'd12;
         6'd48:         dec_type = 4'd13;
         6'd49:         dec_type = 4'd14;
         6'd50:         dec_type = 4'd15;
         default:       dec_type = 4'd0;
      endcase
   end

   // Entry storage; contents are don't-care until marked valid by count.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_ir[wr_ptr]   <= in_ir;
         mem_pc[wr_ptr]   <= in_pc;
         mem_irn[wr_ptr]  <= dec_num;
         mem_type[wr_ptr] <= dec_type;
      end
   end

   // Pointers and occupancy; reset and flush both empty the queue.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   // Head fields, forced to zero when the queue is empty.
   always_comb begin
      out_ir      = '0;
      out_pc      = '0;
      out_irn     = '0;
      out_irtype  = '0;
      out_unknown = 1'b0;
      if (out_valid) begin
         out_ir      = mem_ir[rd_ptr];
         out_pc      = mem_pc[rd_ptr];
         out_irn     = IRN_W'(mem_irn[rd_ptr]);
         out_irtype  = mem_type[rd_ptr];
         out_unknown = (mem_irn[rd_ptr] == 6'd0);
      end
   end
endmodule
